// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. Divides the system clock into a pixel strobe,
//   walks a horizontal/vertical raster and produces registered sync, blanking, scaled
//   framebuffer coordinates, a vblank NMI and a vblank-synchronised double-buffer swap.
//
// Ports
//   i_clk            system clock
//   i_rst_n          asynchronous active-low reset
//   i_enable         raster run; low holds the generator idle at (0,0)
//   i_nmi_enable     enable the vblank NMI
//   i_nmi_ack        level; high clears a pending NMI
//   i_swap_req       one-cycle pulse requesting a buffer swap at the next vblank start
//   o_px_clock       one-cycle pixel strobe, every PX_DIV clocks
//   o_hsync/o_vsync  syncs, active level HSYNC_POL/VSYNC_POL
//   o_hblank         HCount >= H_VISIBLE
//   o_vblank         VCount >= V_VISIBLE
//   o_visible        ~HBlank & ~VBlank
//   o_fb_x/o_fb_y    framebuffer column/row (counters >> SCALE_SHIFT)
//   o_frame_start    pulse with the pixel strobe at raster position (0,0)
//   o_nmi_n          active-low vblank interrupt
//   o_front_buf      buffer currently scanned out
//   o_swap_pending   swap requested but not yet applied
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned PX_DIV      = 2,
    parameter bit          HSYNC_POL   = 1'b0,
    parameter bit          VSYNC_POL   = 1'b0,
    parameter int unsigned SCALE_SHIFT = 2,
    localparam int unsigned FBX_W = ($clog2(H_VISIBLE >> SCALE_SHIFT) > 0) ?
                                    $clog2(H_VISIBLE >> SCALE_SHIFT) : 1,
    localparam int unsigned FBY_W = ($clog2(V_VISIBLE >> SCALE_SHIFT) > 0) ?
                                    $clog2(V_VISIBLE >> SCALE_SHIFT) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic             i_nmi_enable,
    input  logic             i_nmi_ack,
    input  logic             i_swap_req,
    output logic             o_px_clock,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_visible,
    output logic [FBX_W-1:0] o_fb_x,
    output logic [FBY_W-1:0] o_fb_y,
    output logic             o_frame_start,
    output logic             o_nmi_n,
    output logic             o_front_buf,
    output logic             o_swap_pending
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned DW      = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;

    localparam logic [DW-1:0] D_LAST  = DW'(PX_DIV - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_L = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS_L = VW'(V_VISIBLE);
    // Sync windows compared one bit wider so a zero back porch cannot overflow the end value.
    localparam logic [HW:0]   H_SS    = (HW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [HW:0]   H_SE    = (HW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW:0]   V_SS    = (VW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [VW:0]   V_SE    = (VW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0]    r_div;
    logic [HW-1:0]    r_hcount;
    logic [VW-1:0]    r_vcount;
    logic             r_px_clock;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblank;
    logic             r_vblank;
    logic             r_visible;
    logic [FBX_W-1:0] r_fb_x;
    logic [FBY_W-1:0] r_fb_y;
    logic             r_frame_start;
    logic             r_nmi_n;
    logic             r_front_buf;
    logic             r_swap_pending;

    logic [DW-1:0]    w_div_d;
    logic [HW-1:0]    w_h_d;
    logic [VW-1:0]    w_v_d;
    logic             w_tick;
    logic             w_event;
    logic             w_hblank_d;
    logic             w_vblank_d;
    logic             w_hsync_act;
    logic             w_vsync_act;

    // Counter next state. The registered strobe marks the cycle in which the divider sits at
    // PX_DIV-1; the counters step on the edge that ends that cycle.
    always_comb begin
        w_div_d = '0;
        w_h_d   = '0;
        w_v_d   = '0;
        w_tick  = 1'b0;
        w_event = 1'b0;
        if (i_enable) begin
            w_div_d = (r_div == D_LAST) ? '0 : r_div + 1'b1;
            w_tick  = r_px_clock;
            w_h_d   = r_hcount;
            w_v_d   = r_vcount;
            if (w_tick) begin
                if (r_hcount == H_LAST) begin
                    w_h_d = '0;
                    w_v_d = (r_vcount == V_LAST) ? '0 : r_vcount + 1'b1;
                end else begin
                    w_h_d = r_hcount + 1'b1;
                end
            end
            // Vblank start: the strobe that moves the raster onto (0, V_VISIBLE).
            w_event = w_tick && (w_h_d == '0) && (w_v_d == V_VIS_L);
        end
    end

    // Raster outputs are decoded from the next counter values so they register alongside them.
    always_comb begin
        w_hblank_d  = i_enable && (w_h_d >= H_VIS_L);
        w_vblank_d  = i_enable && (w_v_d >= V_VIS_L);
        w_hsync_act = i_enable && ({1'b0, w_h_d} >= H_SS) && ({1'b0, w_h_d} < H_SE);
        w_vsync_act = i_enable && ({1'b0, w_v_d} >= V_SS) && ({1'b0, w_v_d} < V_SE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div          <= '0;
            r_hcount       <= '0;
            r_vcount       <= '0;
            r_px_clock     <= 1'b0;
            r_hsync        <= ~HSYNC_POL;
            r_vsync        <= ~VSYNC_POL;
            r_hblank       <= 1'b0;
            r_vblank       <= 1'b0;
            r_visible      <= 1'b0;
            r_fb_x         <= '0;
            r_fb_y         <= '0;
            r_frame_start  <= 1'b0;
            r_nmi_n        <= 1'b1;
            r_front_buf    <= 1'b0;
            r_swap_pending <= 1'b0;
        end else begin
            r_div         <= w_div_d;
            r_hcount      <= w_h_d;
            r_vcount      <= w_v_d;
            r_px_clock    <= i_enable && (w_div_d == D_LAST);
            r_hsync       <= w_hsync_act ? HSYNC_POL : ~HSYNC_POL;
            r_vsync       <= w_vsync_act ? VSYNC_POL : ~VSYNC_POL;
            r_hblank      <= w_hblank_d;
            r_vblank      <= w_vblank_d;
            r_visible     <= i_enable && !w_hblank_d && !w_vblank_d;
            r_fb_x        <= (i_enable && !w_hblank_d && !w_vblank_d) ?
                             FBX_W'(w_h_d >> SCALE_SHIFT) : '0;
            r_fb_y        <= (i_enable && !w_vblank_d) ? FBY_W'(w_v_d >> SCALE_SHIFT) : '0;
            r_frame_start <= i_enable && (w_div_d == D_LAST) && (w_h_d == '0) && (w_v_d == '0);

            // Vblank start beats a simultaneous acknowledge.
            if (w_event && i_nmi_enable) begin
                r_nmi_n <= 1'b0;
            end else if (i_nmi_ack || !i_nmi_enable) begin
                r_nmi_n <= 1'b1;
            end

            // A request arriving on the vblank edge itself waits for the following vblank.
            if (w_event) begin
                if (r_swap_pending) begin
                    r_front_buf <= ~r_front_buf;
                end
                r_swap_pending <= i_swap_req;
            end else if (i_swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    assign o_px_clock     = r_px_clock;
    assign o_hsync        = r_hsync;
    assign o_vsync        = r_vsync;
    assign o_hblank       = r_hblank;
    assign o_vblank       = r_vblank;
    assign o_visible      = r_visible;
    assign o_fb_x         = r_fb_x;
    assign o_fb_y         = r_fb_y;
    assign o_frame_start  = r_frame_start;
    assign o_nmi_n        = r_nmi_n;
    assign o_front_buf    = r_front_buf;
    assign o_swap_pending = r_swap_pending;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: two instances (a divided-clock mid-size raster and a tiny
// PX_DIV=1 raster with inverted hsync polarity) share random stimulus. A pixel-index model
// pushes the expected output word per cycle into a queue; a monitor pops and compares.
module tb_vga_timing_gen;

    // Instance A configuration
    localparam int A_HV = 32, A_HF = 4, A_HS = 8, A_HB = 4;
    localparam int A_VV = 12, A_VF = 2, A_VS = 2, A_VB = 2;
    localparam int A_PX = 2, A_SH = 2;
    localparam bit A_HP = 1'b0, A_VP = 1'b1;
    // Instance B configuration
    localparam int B_HV = 8, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VV = 4, B_VF = 1, B_VS = 1, B_VB = 1;
    localparam int B_PX = 1, B_SH = 1;
    localparam bit B_HP = 1'b1, B_VP = 1'b0;

    localparam int N_CYC = 16000;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int px; int sh;
        bit hp; bit vp;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n, en, nmien, ack, swp;

    logic       a_px, a_hs, a_vs, a_hb, a_vb, a_vis, a_fs, a_nmi, a_front, a_pend;
    logic [2:0] a_fbx;
    logic [1:0] a_fby;
    logic       b_px, b_hs, b_vs, b_hb, b_vb, b_vis, b_fs, b_nmi, b_front, b_pend;
    logic [1:0] b_fbx;
    logic [0:0] b_fby;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .PX_DIV(A_PX), .HSYNC_POL(A_HP), .VSYNC_POL(A_VP), .SCALE_SHIFT(A_SH)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_nmi_enable(nmien),
        .i_nmi_ack(ack), .i_swap_req(swp),
        .o_px_clock(a_px), .o_hsync(a_hs), .o_vsync(a_vs), .o_hblank(a_hb),
        .o_vblank(a_vb), .o_visible(a_vis), .o_fb_x(a_fbx), .o_fb_y(a_fby),
        .o_frame_start(a_fs), .o_nmi_n(a_nmi), .o_front_buf(a_front),
        .o_swap_pending(a_pend)
    );

    vga_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .PX_DIV(B_PX), .HSYNC_POL(B_HP), .VSYNC_POL(B_VP), .SCALE_SHIFT(B_SH)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_nmi_enable(nmien),
        .i_nmi_ack(ack), .i_swap_req(swp),
        .o_px_clock(b_px), .o_hsync(b_hs), .o_vsync(b_vs), .o_hblank(b_hb),
        .o_vblank(b_vb), .o_visible(b_vis), .o_fb_x(b_fbx), .o_fb_y(b_fby),
        .o_frame_start(b_fs), .o_nmi_n(b_nmi), .o_front_buf(b_front),
        .o_swap_pending(b_pend)
    );

    // Output word: {fby[6:0], fbx[7:0], px, hs, vs, hb, vb, vis, fs, nmi_n, front, pend}
    logic [24:0] act_a, act_b;
    assign act_a = {7'(a_fby), 8'(a_fbx), a_px, a_hs, a_vs, a_hb, a_vb, a_vis, a_fs,
                    a_nmi, a_front, a_pend};
    assign act_b = {7'(b_fby), 8'(b_fbx), b_px, b_hs, b_vs, b_hb, b_vb, b_vis, b_fs,
                    b_nmi, b_front, b_pend};

    logic [24:0] q_a[$];
    logic [24:0] q_b[$];
    int n_chk  = 0;
    int n_fail = 0;

    // Model state: m = enabled edges since idle, p = raster pixel index shown this cycle.
    int m_cnt [2];
    int pix   [2];
    bit strb  [2];
    bit nmi_n [2];
    bit front [2];
    bit pend  [2];

    function automatic cfg_t cfg(input int i);
        cfg_t c;
        if (i == 0) c = '{A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_PX, A_SH, A_HP, A_VP};
        else        c = '{B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_PX, B_SH, B_HP, B_VP};
        return c;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; pix[i] = 0; strb[i] = 1'b0;
            nmi_n[i] = 1'b1; front[i] = 1'b0; pend[i] = 1'b0;
        end
    endfunction

    function automatic bit next_is_event(input int i, input bit en_next);
        cfg_t c = cfg(i);
        int ht = c.hv + c.hf + c.hs + c.hb;
        int frame = ht * (c.vv + c.vf + c.vs + c.vb);
        return en_next && strb[i] && (((pix[i] + 1) % frame) == c.vv * ht);
    endfunction

    // One clock edge with the inputs that were applied before it.
    function automatic void model_edge(input int i, input bit e, input bit ne, input bit ak,
                                       input bit sw);
        cfg_t c = cfg(i);
        int ht = c.hv + c.hf + c.hs + c.hb;
        int frame = ht * (c.vv + c.vf + c.vs + c.vb);
        bit adv;
        bit ev = 1'b0;
        if (!e) begin
            m_cnt[i] = 0; pix[i] = 0; strb[i] = 1'b0;
        end else begin
            adv = strb[i];
            if (adv) pix[i] = (pix[i] + 1) % frame;
            m_cnt[i]++;
            strb[i] = (m_cnt[i] % c.px) == (c.px - 1);
            ev = adv && (pix[i] == c.vv * ht);
        end
        if (ev && ne) nmi_n[i] = 1'b0;
        else if (ak || !ne) nmi_n[i] = 1'b1;
        if (ev) begin
            if (pend[i]) front[i] = ~front[i];
            pend[i] = sw;
        end else if (sw) begin
            pend[i] = 1'b1;
        end
    endfunction

    function automatic logic [24:0] expect_vec(input int i);
        cfg_t c = cfg(i);
        int ht = c.hv + c.hf + c.hs + c.hb;
        int h, v;
        bit hs = 0, vs = 0, hb = 0, vb = 0, vis = 0, fs;
        logic [7:0] fx = '0;
        logic [6:0] fy = '0;
        if (m_cnt[i] != 0) begin
            h   = pix[i] % ht;
            v   = pix[i] / ht;
            hb  = h >= c.hv;
            vb  = v >= c.vv;
            vis = !hb && !vb;
            hs  = (h >= c.hv + c.hf) && (h < c.hv + c.hf + c.hs);
            vs  = (v >= c.vv + c.vf) && (v < c.vv + c.vf + c.vs);
            fx  = vis ? 8'(h >> c.sh) : 8'd0;
            fy  = vb ? 7'd0 : 7'(v >> c.sh);
        end
        fs = strb[i] && (pix[i] == 0) && (m_cnt[i] != 0);
        return {fy, fx, strb[i], hs ? c.hp : ~c.hp, vs ? c.vp : ~c.vp, hb, vb, vis, fs,
                nmi_n[i], front[i], pend[i]};
    endfunction

    function automatic void push_expected();
        q_a.push_back(expect_vec(0));
        q_b.push_back(expect_vec(1));
    endfunction

    // Monitor: compare on the falling edge, away from the active edge.
    int mon_cyc = 0;
    initial begin
        logic [24:0] exp_v;
        forever begin
            @(negedge clk);
            mon_cyc++;
            if (q_a.size() > 0) begin
                exp_v = q_a.pop_front();
                n_chk++;
                if (act_a !== exp_v) begin
                    n_fail++;
                    $display("FAIL instA cyc %0d: got %h expected %h", mon_cyc, act_a, exp_v);
                end
            end
            if (q_b.size() > 0) begin
                exp_v = q_b.pop_front();
                n_chk++;
                if (act_b !== exp_v) begin
                    n_fail++;
                    $display("FAIL instB cyc %0d: got %h expected %h", mon_cyc, act_b, exp_v);
                end
            end
        end
    end

    // Stimulus and model
    initial begin
        int en_off = 0;
        rst_n = 1'b0; en = 1'b0; nmien = 1'b1; ack = 1'b0; swp = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            push_expected();
        end
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) model_edge(i, en, nmien, ack, swp);
            end
            #1;
            // Asynchronous reset in the middle of a frame, checked in the same cycle.
            rst_n = !(cyc == 9000 || cyc == 9001);
            if (cyc == 4000 || cyc == 12345) en_off = 3;
            if (en_off > 0) begin
                en = 1'b0;
                en_off--;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 2999) == 0) en_off = $urandom_range(1, 6);
            end
            if (nmien) nmien = ($urandom_range(0, 1499) != 0);
            else       nmien = ($urandom_range(0, 49) == 0);
            ack = ($urandom_range(0, 299) == 0);
            swp = ($urandom_range(0, 249) == 0);
            // Bias acknowledge and swap requests onto the vblank-start edge.
            if (rst_n && next_is_event(0, en)) begin
                ack = 1'($urandom_range(0, 1));
                swp = 1'($urandom_range(0, 1));
            end
            if (!rst_n) model_reset();
            push_expected();
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
